mouse_packet_decoder: RTL and testbench

Downstream consumer of the PS/2 byte receiver (mouse_read_byte). Collects the receiver's bytes into standard 3-byte PS/2 mouse packets and validates byte-0 sync. Decodes buttons, 9-bit signed X/Y movement and overflow flags, and presents them with a one-cycle valid pulse to the cursor/display logic. Recovers from lost bytes with a sync check and an inter-byte timeout.

---
 rtl/mouse_pkg.sv | 47 ++++
 rtl/mouse_pos_accum.sv | 41 ++++
 rtl/mouse_packet_decoder.sv | 136 +++++++++++++
 tb/tb_mouse_packet_decoder.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/mouse_pkg.sv
// Shared types and helpers for the PS/2 mouse packet path: FSM states,
// status-byte bit positions, decoded-packet layout and the delta decoder.
package mouse_pkg;

    typedef enum logic [1:0] {
        BYTE0 = 2'd0,
        BYTE1 = 2'd1,
        BYTE2 = 2'd2
    } state_t;

    localparam int BTN_L = 0;
    localparam int BTN_R = 1;
    localparam int BTN_M = 2;
    localparam int SYNC  = 3;
    localparam int XSIGN = 4;
    localparam int YSIGN = 5;
    localparam int XOVF  = 6;
    localparam int YOVF  = 7;

    typedef struct packed {
        logic       y_ovf;
        logic       x_ovf;
        logic [8:0] dy;
        logic [8:0] dx;
        logic [2:0] buttons;
    } pkt_t;

    // An overflowed axis reports the largest magnitude its sign allows.
    function automatic logic [8:0] sat_delta(input logic sign, input logic ovf,
                                             input logic [7:0] mag);
        if (ovf) return sign ? 9'h100 : 9'h0FF;
        return {sign, mag};
    endfunction

    function automatic pkt_t decode_packet(input logic [7:0] status,
                                           input logic [7:0] xb,
                                           input logic [7:0] yb);
        pkt_t p;
        p.buttons = {status[BTN_M], status[BTN_R], status[BTN_L]};
        p.dx      = sat_delta(status[XSIGN], status[XOVF], xb);
        p.dy      = sat_delta(status[YSIGN], status[YOVF], yb);
        p.x_ovf   = status[XOVF];
        p.y_ovf   = status[YOVF];
        return p;
    endfunction

endpackage

// File: rtl/mouse_pos_accum.sv
// Clamped cursor accumulator: adds each decoded packet's deltas to the position.
// Latency: updates on the same edge as the decode. Backpressure: none, always accepts.
// Y is subtracted because PS/2 +Y is up while screen Y grows downward.
module mouse_pos_accum #(
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       upd,
    input  logic [8:0] dx,
    input  logic [8:0] dy,
    output logic [9:0] pos_x,
    output logic [9:0] pos_y
);

    logic signed [11:0] sum_x;
    logic signed [11:0] sum_y;

    function automatic logic [9:0] clamp(input logic signed [11:0] v, input int hi);
        if (v < 0) return '0;
        if (v > signed'(12'(hi))) return 10'(hi);
        return v[9:0];
    endfunction

    always_comb begin
        sum_x = signed'({2'b00, pos_x}) + signed'({{3{dx[8]}}, dx});
        sum_y = signed'({2'b00, pos_y}) - signed'({{3{dy[8]}}, dy});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_x <= 10'(SCREEN_W / 2);
            pos_y <= 10'(SCREEN_H / 2);
        end else if (upd) begin
            pos_x <= clamp(sum_x, SCREEN_W - 1);
            pos_y <= clamp(sum_y, SCREEN_H - 1);
        end
    end

endmodule

// File: rtl/mouse_packet_decoder.sv
// Assembles PS/2 receiver bytes into 3-byte mouse packets and decodes them.
// Latency: outputs and o_packet_valid one cycle after byte 2 is accepted. Backpressure: none;
// lost bytes are recovered by the byte-0 sync check and an inter-byte timeout.
// Optional MOUSE_POS_ACCUM_EN adds a clamped cursor position (o_pos_x/o_pos_y).
module mouse_packet_decoder #(
    parameter int TIMEOUT_CYCLES = 100000
`ifdef MOUSE_POS_ACCUM_EN
    ,
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480
`endif
) (
    input  logic       i_driver_clk,
    input  logic       rst_n,
    input  logic [7:0] i_byte,
    input  logic       i_byte_valid,
    output logic [2:0] o_buttons,
    output logic [8:0] o_dx,
    output logic [8:0] o_dy,
    output logic       o_x_ovf,
    output logic       o_y_ovf,
    output logic       o_packet_valid,
    output logic       o_sync_err
`ifdef MOUSE_POS_ACCUM_EN
    ,
    output logic [9:0] o_pos_x,
    output logic [9:0] o_pos_y
`endif
);
    import mouse_pkg::*;

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TO_CNT = CW'(TIMEOUT_CYCLES);

    state_t        state_q, state_d;
    logic          vld_prev_q;
    logic          accept;
    logic          timeout;
    logic [CW-1:0] cnt_q;
    logic [7:0]    status_q, xbyte_q;
    logic          latch_status, latch_x;
    logic          pkt_vld_d, sync_err_d;
    pkt_t          dec_q, dec_next;

    assign accept   = i_byte_valid & ~vld_prev_q;
    assign timeout  = (state_q != BYTE0) && (cnt_q == TO_CNT);
    assign dec_next = decode_packet(status_q, xbyte_q, i_byte);

    always_ff @(posedge i_driver_clk or negedge rst_n) begin
        if (!rst_n) state_q <= BYTE0;
        else        state_q <= state_d;
    end

    // A byte arriving on the timeout cycle is still taken as part of the packet.
    always_comb begin
        state_d      = state_q;
        latch_status = 1'b0;
        latch_x      = 1'b0;
        pkt_vld_d    = 1'b0;
        sync_err_d   = 1'b0;
        case (state_q)
            BYTE0: begin
                if (accept) begin
                    if (i_byte[SYNC]) begin
                        latch_status = 1'b1;
                        state_d      = BYTE1;
                    end else begin
                        sync_err_d = 1'b1;
                    end
                end
            end
            BYTE1: begin
                if (accept) begin
                    latch_x = 1'b1;
                    state_d = BYTE2;
                end else if (timeout) begin
                    sync_err_d = 1'b1;
                    state_d    = BYTE0;
                end
            end
            BYTE2: begin
                if (accept) begin
                    pkt_vld_d = 1'b1;
                    state_d   = BYTE0;
                end else if (timeout) begin
                    sync_err_d = 1'b1;
                    state_d    = BYTE0;
                end
            end
            default: state_d = BYTE0;
        endcase
    end

    always_ff @(posedge i_driver_clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_prev_q     <= 1'b0;
            cnt_q          <= '0;
            status_q       <= '0;
            xbyte_q        <= '0;
            dec_q          <= '0;
            o_packet_valid <= 1'b0;
            o_sync_err     <= 1'b0;
        end else begin
            vld_prev_q     <= i_byte_valid;
            o_packet_valid <= pkt_vld_d;
            o_sync_err     <= sync_err_d;
            if (accept || timeout || state_q == BYTE0) cnt_q <= '0;
            else                                       cnt_q <= cnt_q + CW'(1);
            if (latch_status) status_q <= i_byte;
            if (latch_x)      xbyte_q  <= i_byte;
            if (pkt_vld_d)    dec_q    <= dec_next;
        end
    end

    assign o_buttons = dec_q.buttons;
    assign o_dx      = dec_q.dx;
    assign o_dy      = dec_q.dy;
    assign o_x_ovf   = dec_q.x_ovf;
    assign o_y_ovf   = dec_q.y_ovf;

`ifdef MOUSE_POS_ACCUM_EN
    mouse_pos_accum #(
        .SCREEN_W(SCREEN_W),
        .SCREEN_H(SCREEN_H)
    ) u_pos_accum (
        .clk  (i_driver_clk),
        .rst_n(rst_n),
        .upd  (pkt_vld_d),
        .dx   (dec_next.dx),
        .dy   (dec_next.dy),
        .pos_x(o_pos_x),
        .pos_y(o_pos_y)
    );
`endif

endmodule

// File: tb/tb_mouse_packet_decoder.sv
// Randomized bench for mouse_packet_decoder against a packet-level reference model.
// Define MOUSE_POS_ACCUM_EN to also check the cursor position outputs.
module tb_mouse_packet_decoder;

    localparam int TO = 40;
    localparam int W  = 640;
    localparam int H  = 480;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] byte_dat = 8'h00;
    logic       byte_vld = 1'b0;
    logic [2:0] buttons;
    logic [8:0] dx, dy;
    logic       x_ovf, y_ovf, pkt_vld, sync_err;
    logic [9:0] pos_x, pos_y;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

`ifdef MOUSE_POS_ACCUM_EN
    mouse_packet_decoder #(.TIMEOUT_CYCLES(TO), .SCREEN_W(W), .SCREEN_H(H)) dut (
        .i_driver_clk(clk), .rst_n(rst_n), .i_byte(byte_dat), .i_byte_valid(byte_vld),
        .o_buttons(buttons), .o_dx(dx), .o_dy(dy), .o_x_ovf(x_ovf), .o_y_ovf(y_ovf),
        .o_packet_valid(pkt_vld), .o_sync_err(sync_err), .o_pos_x(pos_x), .o_pos_y(pos_y));
`else
    mouse_packet_decoder #(.TIMEOUT_CYCLES(TO)) dut (
        .i_driver_clk(clk), .rst_n(rst_n), .i_byte(byte_dat), .i_byte_valid(byte_vld),
        .o_buttons(buttons), .o_dx(dx), .o_dy(dy), .o_x_ovf(x_ovf), .o_y_ovf(y_ovf),
        .o_packet_valid(pkt_vld), .o_sync_err(sync_err));
    assign pos_x = 10'd0;
    assign pos_y = 10'd0;
`endif

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int         m_pos;         // bytes of the current packet collected so far
    logic [7:0] m_pk[3];
    logic [2:0] m_btn;
    int         m_dx, m_dy;    // signed deltas as plain integers
    logic       m_xo, m_yo;
    int         m_px, m_py;
    int         k_since = 1000;
    logic [63:0] exp_q[$];
    logic [63:0] obs_q[$];

    function automatic logic [63:0] ev(input logic [1:0] kind);
        logic [8:0] ex = 9'(m_dx);
        logic [8:0] ey = 9'(m_dy);
        logic [9:0] ppx = 10'(m_px);
        logic [9:0] ppy = 10'(m_py);
        return {19'd0, ppx, ppy, kind, m_yo, m_xo, m_btn, ex, ey};
    endfunction

    function automatic int delta(input logic sign, input logic ovf, input logic [7:0] mag);
        if (ovf) return sign ? -256 : 255;
        return sign ? int'(mag) - 256 : int'(mag);
    endfunction

    function automatic int clampi(input int v, input int hi);
        return (v < 0) ? 0 : (v > hi) ? hi : v;
    endfunction

    task automatic model_reset();
        m_pos = 0; m_btn = '0; m_dx = 0; m_dy = 0; m_xo = 0; m_yo = 0;
`ifdef MOUSE_POS_ACCUM_EN
        m_px = W / 2; m_py = H / 2;
`else
        m_px = 0; m_py = 0;
`endif
        k_since = 1000;
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic model_idle(input int k);
        if (m_pos > 0 && k > TO) begin
            exp_q.push_back(ev(2'b10));
            m_pos = 0;
        end
    endtask

    task automatic model_byte(input logic [7:0] b, input int k);
        model_idle(k);
        if (m_pos == 0) begin
            if (b[3]) begin m_pk[0] = b; m_pos = 1; end
            else exp_q.push_back(ev(2'b10));
        end else if (m_pos == 1) begin
            m_pk[1] = b; m_pos = 2;
        end else begin
            m_btn = m_pk[0][2:0];
            m_xo  = m_pk[0][6];
            m_yo  = m_pk[0][7];
            m_dx  = delta(m_pk[0][4], m_pk[0][6], m_pk[1]);
            m_dy  = delta(m_pk[0][5], m_pk[0][7], b);
`ifdef MOUSE_POS_ACCUM_EN
            m_px = clampi(m_px + m_dx, W - 1);
            m_py = clampi(m_py - m_dy, H - 1);
`endif
            exp_q.push_back(ev(2'b01));
            m_pos = 0;
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (rst_n && (pkt_vld || sync_err))
            obs_q.push_back({19'd0, pos_x, pos_y, sync_err, pkt_vld, y_ovf, x_ovf, buttons, dx, dy});
    end

    task automatic compare_events();
        int n;
        chk("event_count", 64'(obs_q.size()), 64'(exp_q.size()));
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) chk("event", obs_q[i], exp_q[i]);
        obs_q.delete();
        exp_q.delete();
    endtask

    // ---------------- stimulus ----------------
    task automatic send_byte(input logic [7:0] b, input int hold, input int gap);
        @(posedge clk);
        #1;
        byte_dat = b;
        byte_vld = 1'b1;
        model_byte(b, k_since);
        repeat (hold) @(posedge clk);
        #1;
        byte_vld = 1'b0;
        @(negedge clk);
        #1;
        compare_events();
        repeat (gap) @(posedge clk);
        k_since = hold + gap + 1;
    endtask

    task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        send_byte(b0, 1, 2);
        send_byte(b1, 2, 1);
        send_byte(b2, 1, 2);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk(tag, {pos_x, pos_y, buttons, dx, dy, x_ovf, y_ovf, pkt_vld, sync_err},
            {10'(m_px), 10'(m_py), 3'd0, 9'd0, 9'd0, 1'b0, 1'b0, 1'b0, 1'b0});
    endtask

    task automatic apply_reset(input string tag);
        #2 rst_n = 1'b0;
        model_reset();
        #2 check_reset_outputs(tag);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        #2 check_reset_outputs("reset_state");
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        send_pkt(8'h08, 8'h05, 8'h03);
        chk("basic_dx", 64'(dx), 64'h005);
        chk("basic_dy", 64'(dy), 64'h003);
        chk("basic_btn_ovf", 64'({buttons, x_ovf, y_ovf}), 64'h0);

        send_pkt(8'h39, 8'hFB, 8'hFE);
        chk("neg_btn", 64'(buttons), 64'h1);
        chk("neg_dx", 64'(dx), 64'h1FB);
        chk("neg_dy", 64'(dy), 64'h1FE);

        send_byte(8'h00, 1, 2);
        send_pkt(8'h08, 8'h01, 8'h01);
        chk("resync_dxdy", 64'({dx, dy}), {46'd0, 9'h001, 9'h001});

        send_byte(8'h08, 1, 2);
        send_byte(8'h10, 1, TO + 10);
        send_pkt(8'h08, 8'h02, 8'h02);
        chk("timeout_dxdy", 64'({dx, dy}), {46'd0, 9'h002, 9'h002});

        send_pkt(8'h48, 8'h7F, 8'h00);
        chk("xovf_flag", 64'(x_ovf), 64'h1);
        chk("xovf_dx", 64'(dx), 64'h0FF);

        send_byte(8'h08, 3, 1);
        send_byte(8'h11, 1, 1);
        apply_reset("midpkt_reset");
        send_pkt(8'h08, 8'h03, 8'h04);
        chk("post_reset_dxdy", 64'({dx, dy}), {46'd0, 9'h003, 9'h004});

`ifdef MOUSE_POS_ACCUM_EN
        apply_reset("pos_reset");
        for (int i = 0; i < 4; i++) send_pkt(8'h08, 8'h64, 8'h00);
        chk("pos_x_clamped", 64'(pos_x), 64'd639);
        chk("pos_y_steady", 64'(pos_y), 64'd240);
`endif

        for (int i = 0; i < 400; i++) begin
            logic [7:0] b;
            int hold, gap;
            b = 8'($urandom);
            if (m_pos == 0 && $urandom_range(0, 7) != 0) b[3] = 1'b1;
            hold = $urandom_range(1, 3);
            gap  = ($urandom_range(0, 9) == 0) ? $urandom_range(TO + 5, TO + 20)
                                               : $urandom_range(0, 3);
            send_byte(b, hold, gap);
            if (i == 200) apply_reset("random_reset");
        end

        repeat (TO + 20) @(posedge clk);
        model_idle(k_since + TO + 20);
        @(negedge clk);
        #1 compare_events();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
